char_rx: RTL and testbench

CHAR_RX -- requirements
Module: char_rx

---
 rtl/char_rx_pkg.sv | 21 ++
 rtl/rx_sync.sv | 25 ++
 rtl/char_rx.sv | 174 +++++++++++++++++
 tb/tb_char_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/char_rx_pkg.sv
// Shared definitions for the serial character receiver and the pattern
// detector that consumes its character stream.
//   state_e      : 3-bit receiver state encoding
//   CHAR_R/CHAR_A: 7-bit ASCII codes used by the downstream detector
//   DATA_BITS    : number of data bits per character
package char_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_WAIT_HI = 3'd5
  } state_e;

  localparam logic [6:0] CHAR_R    = 7'h52;
  localparam logic [6:0] CHAR_A    = 7'h41;
  localparam int         DATA_BITS = 7;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
//   clk : receiver clock
//   rst : asynchronous active-low reset; both flops reset to 1 (idle line)
//   d   : asynchronous input
//   q   : synchronized output
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_q <= 2'b11;
    end else begin
      ff_q <= {ff_q[0], d};
    end
  end

  assign q = ff_q[1];

endmodule

// File: rtl/char_rx.sv
// Serial receiver for 7-bit characters: start bit, 7 data bits LSB first,
// optional even-parity bit, one stop bit.
//   CLKS_PER_BIT : clock cycles per bit period (even, >= 4)
//   PARITY_EN    : 1 = an even-parity bit follows the data bits
//   clk          : clock
//   rst          : asynchronous active-low reset
//   rx           : asynchronous serial line, idle high
//   char_out     : last accepted character, held until the next one
//   char_valid   : one-cycle strobe for a newly accepted char_out
//   frame_err    : one-cycle strobe when the stop bit is sampled low
//   parity_err   : one-cycle strobe on parity mismatch (PARITY_EN=1 only)
module char_rx
  import char_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [6:0] char_out,
  output logic       char_valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int             BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  FULL_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]  HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_s;
  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    shift_q, shift_d;
  logic          par_bad_q, par_bad_d;
  logic [6:0]    char_q, char_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          perr_q, perr_d;
  logic          tick;

  rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // START waits half a bit to land in the middle of the start bit; every
  // later sample is one full bit period after the previous one.
  assign tick = (state_q == ST_START) ? (baud_q == HALF_LAST)
                                      : (baud_q == FULL_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    char_d    = char_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!rx_s) begin
          state_d   = ST_START;
          bit_d     = '0;
          par_bad_d = 1'b0;
        end
      end

      ST_START: begin
        if (tick) begin
          baud_d  = '0;
          // a start bit that has gone high again by mid-bit is a glitch
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (tick) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[6:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (tick) begin
          baud_d    = '0;
          par_bad_d = (^shift_q) ^ rx_s;
          state_d   = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (tick) begin
          baud_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              char_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            // framing error wins over any parity error in the same frame
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HI;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_WAIT_HI: begin
        // a held-low line (break) must not be mistaken for new start bits
        baud_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      char_q    <= 7'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      char_q    <= char_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_char_rx.sv
module tb_char_rx;
  import char_rx_pkg::*;

  localparam int C = 16;

  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;

  typedef struct {
    int         cyc;
    logic [1:0] kind;
    logic [6:0] ch;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic       rx0, rx1;
  logic [6:0] co0, co1;
  logic       v0, v1, fe0, fe1, pe0, pe1;

  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [6:0] mchar[2];
  int         first_valid0 = -1;
  int         valid_cnt0 = 0;
  int         ferr_cnt0 = 0;
  int         perr_cnt1 = 0;
  int         valid_cnt1 = 0;
  logic [27:0] hist = '0;
  logic       match_seen = 1'b0;

  char_rx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .rx(rx0), .char_out(co0),
    .char_valid(v0), .frame_err(fe0), .parity_err(pe0)
  );

  char_rx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .rx(rx1), .char_out(co1),
    .char_valid(v1), .frame_err(fe1), .parity_err(pe1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  // Per-cycle comparison of one receiver against the frame-level model.
  task automatic check_dut(input int sel, input logic rst_n, input logic v,
                           input logic fe, input logic pe, input logic [6:0] co);
    exp_t e;
    logic have;
    logic [2:0] want;
    have = 1'b0;
    want = 3'b000;
    e.cyc = 0; e.kind = K_VALID; e.ch = '0;
    if (sel == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); have = 1'b1; end
    if (sel == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); have = 1'b1; end
    if (!rst_n) mchar[sel] = 7'h00;
    if (have) begin
      case (e.kind)
        K_VALID: begin want = 3'b100; mchar[sel] = e.ch; end
        K_FERR:  want = 3'b010;
        default: want = 3'b001;
      endcase
    end
    tests++;
    if ({v, fe, pe} !== want) begin
      fails++;
      $display("FAIL strobes dut%0d cyc=%0d got={v,fe,pe}=%b expected=%b", sel, cyc, {v, fe, pe}, want);
    end
    tests++;
    if (co !== mchar[sel]) begin
      fails++;
      $display("FAIL char_out dut%0d cyc=%0d got=%h expected=%h", sel, cyc, co, mchar[sel]);
    end
    if (sel == 0) begin
      if (v) begin
        valid_cnt0++;
        if (first_valid0 < 0) first_valid0 = cyc;
        hist = {hist[20:0], co};
        if (hist == {CHAR_R, CHAR_A, CHAR_R, CHAR_A}) match_seen = 1'b1;
      end
      if (fe) ferr_cnt0++;
    end else begin
      if (v) valid_cnt1++;
      if (pe) perr_cnt1++;
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check_dut(0, rst0, v0, fe0, pe0, co0);
      check_dut(1, rst1, v1, fe1, pe1, co1);
    end
  endtask

  task automatic drive(input int sel, input logic b, input int n);
    if (sel == 0) rx0 = b; else rx1 = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one frame starting now; records the outcome and the cycle in which
  // its strobe must appear: fall + 2 sync + half bit + N bits + 1.
  task automatic send_frame(input int sel, input logic [6:0] ch,
                            input logic par, input logic stop);
    exp_t e;
    int n;
    n = (sel == 1) ? 9 : 8;
    e.cyc = cyc + 2 + C / 2 + n * C + 1;
    e.ch  = ch;
    if (!stop) e.kind = K_FERR;
    else if (sel == 1 && ((^ch) ^ par)) e.kind = K_PERR;
    else e.kind = K_VALID;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    drive(sel, 1'b0, C);
    for (int i = 0; i < 7; i++) drive(sel, ch[i], C);
    if (sel == 1) drive(sel, par, C);
    drive(sel, stop, C);
  endtask

  initial begin
    int f_r;
    mchar[0] = 7'h00;
    mchar[1] = 7'h00;
    rst0 = 1'b0; rst1 = 1'b0;
    rx0 = 1'b1;  rx1 = 1'b1;
    @(posedge clk); #1;
    fork
      compare_loop();
    join_none

    // reset held with the line toggling
    for (int i = 0; i < 12; i++) begin
      rx0 = i[0];
      rx1 = ~i[0];
      @(posedge clk); #1;
    end
    rx0 = 1'b1; rx1 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b1, 20);

    // single 'R', latency pinned to a literal
    f_r = cyc;
    send_frame(0, CHAR_R, 1'b0, 1'b1);
    drive(0, 1'b1, 20);
    check("latency_R", first_valid0 - f_r, 139);
    check("char_R", int'(co0), 'h52);
    check("match_before", int'(match_seen), 0);

    // back-to-back R A R A
    send_frame(0, CHAR_R, 1'b0, 1'b1);
    send_frame(0, CHAR_A, 1'b0, 1'b1);
    send_frame(0, CHAR_R, 1'b0, 1'b1);
    send_frame(0, CHAR_A, 1'b0, 1'b1);
    drive(0, 1'b1, 20);
    check("valid_count", valid_cnt0, 5);
    check("match_after", int'(match_seen), 1);
    check("char_A", int'(co0), 'h41);

    // start glitch
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 40);
    check("glitch_valid_count", valid_cnt0, 5);

    // framing error followed by a long break, then recovery
    send_frame(0, CHAR_A, 1'b0, 1'b0);
    drive(0, 1'b0, 40 * C);
    drive(0, 1'b1, 2 * C);
    check("break_ferr_count", ferr_cnt0, 1);
    send_frame(0, CHAR_R, 1'b0, 1'b1);
    drive(0, 1'b1, 20);
    check("recover_char", int'(co0), 'h52);

    // parity receiver
    send_frame(1, CHAR_R, 1'b1, 1'b1);
    drive(1, 1'b1, 10);
    send_frame(1, CHAR_R, 1'b0, 1'b1);
    drive(1, 1'b1, 20);
    check("par_valid_count", valid_cnt1, 1);
    check("par_err_count", perr_cnt1, 1);

    // reset in the middle of the data bits: frame aborted, no strobe
    drive(1, 1'b0, C);
    drive(1, 1'b0, C);
    drive(1, 1'b1, C);
    drive(1, 1'b0, C / 2);
    rst1 = 1'b0;
    drive(1, 1'b1, 5);
    rst1 = 1'b1;
    drive(1, 1'b1, 12 * C);
    check("abort_valid_count", valid_cnt1, 1);
    check("abort_char", int'(co1), 0);
    send_frame(1, CHAR_A, 1'b0, 1'b1);
    drive(1, 1'b1, 20);
    check("after_abort_valid", valid_cnt1, 2);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
